des_f_pipe: RTL and testbench
=============================

# des_f_pipe

Two-stage pipelined DES Feistel f-function with valid/ready handshaking.
- Stage 1 expands the 32-bit right half R to 48 bits (E table) and XORs it with the 48-bit round subkey.
- Stage 2 passes the eight 6-bit chunks through instances `s_box_1` … `s_box_8` (port `index[5:0]` → `sub_val[3:0]`), concatenates the 32 bits and applies the P permutation.
- Sits between the round-key scheduler/round controller (upstream) and the Feistel XOR/swap logic (downstream).
- A user tag travels alongside each operation.

## Interface
Parameters:
- `TAG_W`, default 4: width of the sideband tag carried with each operation.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input operation valid.
- `in_ready` out 1: block can accept an input this cycle.
- `in_r` in 32: right half R; DES bit 1 is `in_r[31]`.
- `in_key` in 48: round subkey; DES bit 1 is `in_key[47]`.
- `in_tag` in TAG_W: sideband, returned unchanged.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_f` out 32: f(R,K) after P; DES bit 1 is `out_f[31]`.
- `out_tag` out TAG_W: tag of the result.

## Operation
- Bit convention: DES bit n maps to vector bit (W−n), with W = 32 or 48.
- E table, DES bit order: 32 1 2 3 4 5 4 5 6 7 8 9 8 9 10 11 12 13 12 13 14 15 16 17 16 17 18 19 20 21 20 21 22 23 24 25 24 25 26 27 28 29 28 29 30 31 32 1.
- Stage 1 register stores `s1_x = E(in_r) ^ in_key` (48 bits), plus `in_tag`, plus `s1_valid`.
- S-box n (n = 1..8) receives `s1_x[47-6(n-1) -: 6]`. `s_box_1` takes the MSB chunk.
- S-box outputs are concatenated with S1 in bits [31:28] down to S8 in bits [3:0].
- P table, DES bit order: 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
- Stage 2 register stores the permuted 32-bit result, the tag, and `s2_valid`. Outputs come directly from stage-2 registers: `out_valid = s2_valid`, no combinational data path to the outputs.
- Handshake logic:
  - s2_load = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_load.
  - in_ready = !s1_valid || s2_load.
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- On s2_load: s2_valid ← s1_valid, and stage-2 data ← stage-2 logic result.
- s1_valid update:
  - On input transfer: s1_valid ← 1 and stage-1 data loads.
  - Else, if s1_adv: s1_valid ← 0.
- Simultaneous input transfer and s1_adv in the same cycle: stage 1 reloads with the new operation. No bubble.
- Stalled stages hold their data and tags unchanged, bit-exact.
- Data and tag registers load only when their stage loads. This avoids toggling when idle.
- `out_valid` never deasserts without an output transfer. `out_f`/`out_tag` stay stable while out_valid && !out_ready.
- Invalid input values do not exist: any R/K is legal.

## Timing
- Reset, rst=1 at a clock edge:
  - s1_valid=0 and s2_valid=0, so out_valid=0.
  - All data/tag registers reset to 0, so out_f=0 and out_tag=0.
  - in_ready=1 in the cycle after reset.
- Reset has priority over any transfer in the same cycle. Operations in flight are discarded, with no output.
- Latency is 2 cycles. An input accepted at edge k gives out_valid=1 after edge k+2, when out_ready was 1 at edge k+1.
- Throughput is 1 operation/cycle while out_ready=1.
- Capacity is 2 operations.
- in_ready falls only when both stages are full and out_ready=0.
- in_ready is combinational from out_ready. This is the only combinational input-to-output path.

## Test plan
- Reset then idle: out_valid=0, out_f=0, in_ready=1. Hold in_valid=0 for 10 cycles → out_valid stays 0.
- Zero vector: R=0x00000000, K=0x000000000000, tag=3 → after 2 cycles out_f=0xD8D8DBBC, out_tag=3.
- FIPS round 1: R=0xF0AAF0AA, K=0x1B02EFFC7072 → out_f=0x234AA9BB.
- Streaming: 16 back-to-back random R/K with out_ready=1.
  - Results match the golden model in order.
  - Tags match.
  - One result per cycle after 2-cycle fill.
- Backpressure: out_ready=0 for 5 cycles with continuous input.
  - in_ready falls after exactly 2 accepts.
  - out_f is held stable.
  - Releasing out_ready drains the results in order, with no loss or duplication.
- Mid-operation reset: two operations in flight, rst pulsed for 1 cycle.
  - out_valid=0 the next cycle.
  - Neither result ever appears.
  - A new input gives a correct result 2 cycles later.

Source files
------------

// File: rtl/des_f_pipe.sv
// Two-stage pipelined DES Feistel f-function: E-expansion/key-mix, then S-boxes and P.
// Valid/ready handshake with a sideband tag carried alongside each operation.

module des_sbox #(
  parameter logic [255:0] TBL = 256'h0
) (
  input  logic [5:0] index,
  output logic [3:0] sub_val
);
  logic [7:0] bit_pos_s;

  // Row is the outer bit pair, column the middle four; row 0 column 0 is the top nibble.
  always_comb begin
    bit_pos_s = 8'd255 - {index[5], index[0], index[4:1], 2'b00};
    sub_val   = TBL[bit_pos_s -: 4];
  end
endmodule

module des_f_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_r,
  input  logic [47:0]      in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_f,
  output logic [TAG_W-1:0] out_tag
);
  // P table entries stored as (DES bit - 1), first entry in the top five bits.
  localparam logic [159:0] P_TBL = {
    5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
    5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
    5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
    5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
  };

  logic             s1_valid_r, s2_valid_r;
  logic [47:0]      s1_x_r;
  logic [TAG_W-1:0] s1_tag_r, s2_tag_r;
  logic [31:0]      s2_f_r;
  logic [47:0]      e_s;
  logic [31:0]      s_cat_s, p_s;
  logic             s2_load_s, s1_adv_s, in_xfer_s;

  // Handshake: stage 2 frees when empty or draining; stage 1 frees when empty or advancing.
  always_comb begin
    s2_load_s = !s2_valid_r || out_ready;
    s1_adv_s  = s1_valid_r && s2_load_s;
    in_ready  = !s1_valid_r || s2_load_s;
    in_xfer_s = in_valid && in_ready;
  end

  // E expansion: output block b takes R bits 4b..4b+5 (DES numbering, wrapping at 32).
  always_comb begin
    e_s = 48'h0;
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < 6; p++) begin
        e_s[47 - 6*b - p] = in_r[31 - ((4*b + p + 31) % 32)];
      end
    end
  end

  des_sbox #(.TBL(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D))
    s_box_1 (.index(s1_x_r[47:42]), .sub_val(s_cat_s[31:28]));
  des_sbox #(.TBL(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9))
    s_box_2 (.index(s1_x_r[41:36]), .sub_val(s_cat_s[27:24]));
  des_sbox #(.TBL(256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C))
    s_box_3 (.index(s1_x_r[35:30]), .sub_val(s_cat_s[23:20]));
  des_sbox #(.TBL(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E))
    s_box_4 (.index(s1_x_r[29:24]), .sub_val(s_cat_s[19:16]));
  des_sbox #(.TBL(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453))
    s_box_5 (.index(s1_x_r[23:18]), .sub_val(s_cat_s[15:12]));
  des_sbox #(.TBL(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D))
    s_box_6 (.index(s1_x_r[17:12]), .sub_val(s_cat_s[11:8]));
  des_sbox #(.TBL(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C))
    s_box_7 (.index(s1_x_r[11:6]),  .sub_val(s_cat_s[7:4]));
  des_sbox #(.TBL(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B))
    s_box_8 (.index(s1_x_r[5:0]),   .sub_val(s_cat_s[3:0]));

  // P permutation of the concatenated S-box outputs.
  always_comb begin
    p_s = 32'h0;
    for (int i = 0; i < 32; i++) begin
      p_s[31 - i] = s_cat_s[5'd31 - P_TBL[159 - 5*i -: 5]];
    end
  end

  // Pipeline registers; data and tags load only when their stage actually takes an operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s1_x_r     <= 48'h0;
      s1_tag_r   <= '0;
      s2_f_r     <= 32'h0;
      s2_tag_r   <= '0;
    end else begin
      if (s2_load_s) begin
        s2_valid_r <= s1_valid_r;
      end
      if (s1_adv_s) begin
        s2_f_r   <= p_s;
        s2_tag_r <= s1_tag_r;
      end
      if (in_xfer_s) begin
        s1_valid_r <= 1'b1;
        s1_x_r     <= e_s ^ in_key;
        s1_tag_r   <= in_tag;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_f     = s2_f_r;
  assign out_tag   = s2_tag_r;
endmodule

// File: tb/tb_des_f_pipe.sv
// Self-checking bench for des_f_pipe: directed steps plus random traffic against
// a table-driven DES f-function model and an in-order scoreboard.

module tb_des_f_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_r = 32'h0;
  logic [47:0] in_key = 48'h0;
  logic [3:0]  in_tag = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_f;
  logic [3:0]  out_tag;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] f;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb_q[$];

  des_f_pipe #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_key(in_key), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int e_t [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int sbx [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // Reference f(R,K) straight from the DES tables (DES bit n is vector bit W-n).
  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  six;
    int          row, col;
    for (int j = 0; j < 48; j++) x[47-j] = r[32-e_t[j]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      row = {six[5], six[0]};
      col = six[4:1];
      s[31-4*b -: 4] = 4'(sbx[b][row*16+col]);
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[32-p_t[i]];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update scoreboard for transfers.
  task automatic cycle(input logic v, input logic [31:0] r, input logic [47:0] k,
                       input logic [3:0] t, input logic ordy,
                       output logic acc, output logic rdy, output logic ov,
                       output logic [31:0] of, output logic [3:0] ot);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_r = r; in_key = k; in_tag = t; out_ready = ordy;
    #1;
    rdy = in_ready; ov = out_valid; of = out_f; ot = out_tag;
    acc = v && in_ready;
    if (!rst) begin
      if (out_valid && out_ready) begin
        chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_f", 64'(out_f), 64'(e.f));
          chk("sb_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (acc) sb_q.push_back('{f_ref(r, k), t});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        acc, rdy, ov;
    logic [31:0] of, f0, pr;
    logic [3:0]  ot, pt;
    logic [47:0] pk;
    int          acc_cnt, guard;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_out_f", 64'(of), 64'd0);
    chk("rst_out_tag", 64'(ot), 64'd0);
    chk("rst_in_ready", 64'(rdy), 64'd1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
      chk("idle_out_valid", 64'(ov), 64'd0);
    end

    // Zero vector: two-cycle latency, known constant
    cycle(1'b1, 32'h0, 48'h0, 4'd3, 1'b1, acc, rdy, ov, of, ot);
    chk("zero_accept", 64'(acc), 64'd1);
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("zero_lat1_valid", 64'(ov), 64'd0);
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("zero_lat2_valid", 64'(ov), 64'd1);
    chk("zero_f", 64'(of), 64'hD8D8DBBC);
    chk("zero_tag", 64'(ot), 64'd3);

    // FIPS round-1 vector
    cycle(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 4'd9, 1'b1, acc, rdy, ov, of, ot);
    chk("fips_accept", 64'(acc), 64'd1);
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("fips_valid", 64'(ov), 64'd1);
    chk("fips_f", 64'(of), 64'h234AA9BB);
    chk("fips_tag", 64'(ot), 64'd9);

    // Streaming: 16 back-to-back random operations
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, $urandom, {16'($urandom), 32'($urandom)}, 4'(i), 1'b1, acc, rdy, ov, of, ot);
      chk("stream_accept", 64'(acc), 64'd1);
      chk("stream_valid", 64'(ov), 64'(i >= 2));
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
      chk("stream_drain_valid", 64'(ov), 64'd1);
    end
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("stream_empty_valid", 64'(ov), 64'd0);
    chk("stream_sb_empty", 64'(sb_q.size()), 64'd0);

    // Backpressure: out_ready low for 5 cycles with continuous input
    pr = $urandom; pk = {16'($urandom), 32'($urandom)}; pt = 4'($urandom);
    acc_cnt = 0;
    f0 = 32'h0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, pr, pk, pt, 1'b0, acc, rdy, ov, of, ot);
      chk("bp_accept", 64'(acc), 64'(c < 2));
      if (acc) begin
        acc_cnt++;
        pr = $urandom; pk = {16'($urandom), 32'($urandom)}; pt = 4'($urandom);
      end
      if (c == 2) begin
        chk("bp_valid", 64'(ov), 64'd1);
        f0 = of;
      end else if (c > 2) begin
        chk("bp_f_stable", 64'(of), 64'(f0));
      end
    end
    chk("bp_accept_count", 64'(acc_cnt), 64'd2);
    guard = 0;
    while (sb_q.size() != 0 && guard < 10) begin
      cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
      guard++;
    end
    chk("bp_drained", 64'(sb_q.size()), 64'd0);
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("bp_no_dup", 64'(ov), 64'd0);

    // Mid-operation reset with two operations in flight
    cycle(1'b1, $urandom, {16'($urandom), 32'($urandom)}, 4'd5, 1'b1, acc, rdy, ov, of, ot);
    cycle(1'b1, $urandom, {16'($urandom), 32'($urandom)}, 4'd6, 1'b1, acc, rdy, ov, of, ot);
    chk("mr_second_accept", 64'(acc), 64'd1);
    rst = 1'b1;
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("mr_valid_cleared", 64'(ov), 64'd0);
    chk("mr_f_cleared", 64'(of), 64'd0);
    chk("mr_in_ready", 64'(rdy), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
      chk("mr_no_ghost", 64'(ov), 64'd0);
    end
    pr = $urandom; pk = {16'($urandom), 32'($urandom)};
    cycle(1'b1, pr, pk, 4'd12, 1'b1, acc, rdy, ov, of, ot);
    chk("mr_new_accept", 64'(acc), 64'd1);
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("mr_new_lat1", 64'(ov), 64'd0);
    cycle(1'b0, 32'h0, 48'h0, 4'h0, 1'b1, acc, rdy, ov, of, ot);
    chk("mr_new_valid", 64'(ov), 64'd1);
    chk("mr_new_f", 64'(of), 64'(f_ref(pr, pk)));
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
